stream_pipeline_ctrl: RTL
=========================

# stream_pipeline_ctrl

Parametrised frame-level pipeline controller for the motion-detector datapath, and the successor to the fixed three-stage control unit. It gates a streaming pixel handshake, generates one enable per pipeline stage with per-stage frame warm-up, and shadows width, height and threshold configuration so that new values apply only at frame boundaries. It also checks frame length against the configured geometry and drops malformed frames. It sits between the input stream port, the output stream port and all processing stages.

## Interface
- NUM_STAGES, 3: number of pipeline stages driven; the last stage feeds the output stream.
- FIRST_LAG, 2: completed frames required before stage 1 enables; stage k≥1 enables after FIRST_LAG+k−1 completed frames.
- W_W, 11: width field bits. H_W, 10: height field bits. T_W, 8: threshold bits.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  input beat valid
- s_last  in  1  input beat is final beat of frame
- s_ready  out  1  input beat accepted when s_valid&&s_ready
- m_ready  in  1  downstream ready
- m_valid  out  1  output beat valid
- cfg_valid  in  1  config write strobe
- cfg_ready  out  1  always 1 out of reset
- cfg_width_in / cfg_height_in / cfg_thr_in  in  W_W / H_W / T_W  config write data
- cfg_width / cfg_height / cfg_threshold  out  W_W / H_W / T_W  active config
- stage_enb  out  NUM_STAGES  per-stage beat enable
- frame_start  out  1  pulse on first accepted beat of a frame
- err_len  out  1  one-cycle pulse on frame-length violation
- warm  out  1  all stages active

## Operation
- Accept: acc = s_valid && s_ready. s_ready = cfg_ok && (m_ready || !act[NUM_STAGES−1] || st==DROP), where cfg_ok = active width≠0 && height≠0.
- act[0]=1. For k≥1, act[k] = (fcnt ≥ FIRST_LAG+k−1). fcnt saturates at FIRST_LAG+NUM_STAGES−2, width $clog2(FIRST_LAG+NUM_STAGES).
- stage_enb[k] = acc && act[k] && st!=DROP. m_valid = s_valid && act[NUM_STAGES−1] && cfg_ok && st!=DROP.
- Config: cfg_valid loads the pending registers and sets pend. Pending values copy to active when pend is set and either st==IDLE or acc&&s_last; pend then clears. A write coinciding with a boundary goes straight to active.
- FSM st: IDLE, IN_FRAME, DROP.
  - IDLE→IN_FRAME on acc&&!s_last; frame_start=1. A single-beat frame (acc&&s_last in IDLE) is checked against W·H=1.
  - IN_FRAME: beat counter bcnt (width W_W+H_W) increments per acc.
    - acc&&s_last with bcnt+1==W·H: fcnt++, →IDLE.
    - acc&&s_last with bcnt+1≠W·H: err_len, fcnt unchanged, →IDLE.
    - acc&&!s_last with bcnt+1==W·H: err_len, →DROP.
  - DROP: beats are accepted and discarded (no stage_enb, m_valid=0); →IDLE on acc&&s_last.
- warm = act[NUM_STAGES−1].

## Timing
- Reset values: st=IDLE, fcnt=0, bcnt=0, pend=0, active and pending config 0, so s_ready=0. stage_enb=0, m_valid=0, frame_start=0, err_len=0, warm=0, cfg_ready=1.
- stage_enb, m_valid and s_ready are combinational from inputs and state, with zero latency. fcnt and act update the cycle after the last beat.
- A new config is visible on cfg_* the cycle after the boundary beat. The boundary beat itself uses the old config.
- A deasserted m_ready while warm stalls input with no beat loss. Before warm, m_ready is ignored.
- Asserting rst_n low mid-frame discards the frame and clears warm-up immediately.

## Structure
- Package stream_pipeline_ctrl_pkg: state enum (IDLE, IN_FRAME, DROP) and the default field widths.
- Sub-module frame_len_checker: owns bcnt, the W·H product and the end/early/late comparison. Outputs: len_ok, len_short, len_overrun.

## Test plan
- Config 4×2, thr 20; stream 4 frames of 8 beats with m_ready=1 → stage_enb[0] on all 32 beats. stage_enb[1] from frame 3, stage_enb[2] and m_valid from frame 4. warm rises after frame 3 ends.
- Frame with s_last on beat 5 of 8 → err_len pulse on beat 5; fcnt unchanged; next frame accepted normally.
- Frame of 10 beats, config 8 → err_len on beat 8; beats 9–10 accepted with stage_enb=0 and m_valid=0; IDLE after beat 10.
- Config write 6×2 mid-frame while configured 4×2 → cfg_width stays 4 until the cycle after the last beat, then 6; next 12-beat frame passes.
- Warm pipeline, m_ready=0 for 5 cycles mid-frame → s_ready=0 and stage_enb=0 throughout; no beat lost and beat count stays correct.
- rst_n low on beat 3 of frame 2 → all outputs at reset values; s_ready=0 until a config write.

Source files
------------

// File: rtl/stream_pipeline_ctrl_pkg.sv
// Shared types and default geometry for the stream pipeline controller.
package stream_pipeline_ctrl_pkg;

    localparam int DEF_NUM_STAGES = 3;
    localparam int DEF_FIRST_LAG  = 2;
    localparam int DEF_W_W        = 11;
    localparam int DEF_H_W        = 10;
    localparam int DEF_T_W        = 8;

    // Frame-level controller state.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_FRAME = 2'd1,
        DROP     = 2'd2
    } state_t;

endpackage

// File: rtl/stream_pipeline_ctrl_frame_len_checker.sv
// Counts accepted beats of the current frame and compares the running
// count against the configured width*height geometry.
module frame_len_checker
    import stream_pipeline_ctrl_pkg::*;
#(
    parameter int W_W = DEF_W_W,
    parameter int H_W = DEF_H_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_acc,        // counted beat (not asserted while dropping)
    input  logic           i_last,
    input  logic [W_W-1:0] i_width,
    input  logic [H_W-1:0] i_height,
    output logic           o_len_ok,     // last beat lands exactly on W*H
    output logic           o_len_short,  // last beat arrives before W*H
    output logic           o_len_overrun // W*H reached without last
);

    localparam int PW = W_W + H_W;

    logic [PW-1:0] r_bcnt;
    logic [PW-1:0] w_prod;
    logic [PW-1:0] w_next;
    logic          w_match;

    assign w_prod  = PW'(i_width) * PW'(i_height);
    assign w_next  = r_bcnt + PW'(1);
    assign w_match = (w_next == w_prod);

    assign o_len_ok      = i_acc &&  i_last &&  w_match;
    assign o_len_short   = i_acc &&  i_last && !w_match;
    assign o_len_overrun = i_acc && !i_last &&  w_match;

    // Beat counter: advances per counted beat, restarts at any frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt <= '0;
        end else if (i_acc) begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            r_bcnt <= (i_last || w_match) ? '0 : w_next;
        end
    end

endmodule

// File: rtl/stream_pipeline_ctrl.sv
// Frame-level pipeline controller: gates the pixel handshake, issues
// per-stage enables with frame warm-up, shadows configuration until a
// frame boundary and drops frames whose length disagrees with W*H.
module stream_pipeline_ctrl
    import stream_pipeline_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int FIRST_LAG  = DEF_FIRST_LAG,
    parameter int W_W        = DEF_W_W,
    parameter int H_W        = DEF_H_W,
    parameter int T_W        = DEF_T_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  m_ready,
    output logic                  m_valid,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [W_W-1:0]        cfg_width_in,
    input  logic [H_W-1:0]        cfg_height_in,
    input  logic [T_W-1:0]        cfg_thr_in,
    output logic [W_W-1:0]        cfg_width,
    output logic [H_W-1:0]        cfg_height,
    output logic [T_W-1:0]        cfg_threshold,
    output logic [NUM_STAGES-1:0] stage_enb,
    output logic                  frame_start,
    output logic                  err_len,
    output logic                  warm
);

    localparam int FC_MAX = FIRST_LAG + NUM_STAGES - 2;
    localparam int FC_W   = $clog2(FIRST_LAG + NUM_STAGES);

    state_t          r_st, w_st_next;
    logic [FC_W-1:0] r_fcnt;
    logic [NUM_STAGES-1:0] w_act;

    logic [W_W-1:0]  r_act_w,  r_pend_w;
    logic [H_W-1:0]  r_act_h,  r_pend_h;
    logic [T_W-1:0]  r_act_t,  r_pend_t;
    logic            r_pend;

    logic w_cfg_ok;
    logic w_acc;
    logic w_dropping;
    logic w_boundary;
    logic w_len_ok, w_len_short, w_len_overrun;
    logic w_frame_start, w_err_len;

    assign w_cfg_ok   = (r_act_w != '0) && (r_act_h != '0);
    assign w_dropping = (r_st == DROP);
    assign s_ready    = w_cfg_ok && (m_ready || !w_act[NUM_STAGES-1] || w_dropping);
    assign w_acc      = s_valid && s_ready;
    assign w_boundary = (r_st == IDLE) || (w_acc && s_last);

    assign m_valid    = s_valid && w_act[NUM_STAGES-1] && w_cfg_ok && !w_dropping;
    assign warm       = w_act[NUM_STAGES-1];
    assign cfg_ready  = 1'b1;
    assign cfg_width     = r_act_w;
    assign cfg_height    = r_act_h;
    assign cfg_threshold = r_act_t;
    assign frame_start   = w_frame_start;
    assign err_len       = w_err_len;

    frame_len_checker #(
        .W_W (W_W),
        .H_W (H_W)
    ) u_len (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_acc         (w_acc && !w_dropping),
        .i_last        (s_last),
        .i_width       (r_act_w),
        .i_height      (r_act_h),
        .o_len_ok      (w_len_ok),
        .o_len_short   (w_len_short),
        .o_len_overrun (w_len_overrun)
    );

    // Stage activity from the completed-frame count; stage 0 is always live.
    always_comb begin
        w_act    = '0;
        w_act[0] = 1'b1;
        for (int k = 1; k < NUM_STAGES; k++) begin
            w_act[k] = (int'(r_fcnt) >= FIRST_LAG + k - 1);
        end
    end

    // Per-stage beat enables; nothing advances while a frame is dropped.
    always_comb begin
        stage_enb = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_enb[k] = w_acc && w_act[k] && !w_dropping;
        end
    end

    // Completed-frame counter, saturating once every stage is warm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt <= '0;
        end else if (w_len_ok && (r_fcnt != FC_W'(FC_MAX))) begin
            r_fcnt <= r_fcnt + FC_W'(1);
        end
    end

    // Config shadowing: writes land in pending and move to active at a boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_w  <= '0;
            r_act_h  <= '0;
            r_act_t  <= '0;
            r_pend_w <= '0;
            r_pend_h <= '0;
            r_pend_t <= '0;
            r_pend   <= 1'b0;
        end else begin
            if (cfg_valid) begin
                r_pend_w <= cfg_width_in;
                r_pend_h <= cfg_height_in;
                r_pend_t <= cfg_thr_in;
            end
            if (cfg_valid && w_boundary) begin
                r_act_w <= cfg_width_in;
                r_act_h <= cfg_height_in;
                r_act_t <= cfg_thr_in;
                r_pend  <= 1'b0;
            end else if (cfg_valid) begin
                r_pend  <= 1'b1;
            end else if (r_pend && w_boundary) begin
                r_act_w <= r_pend_w;
                r_act_h <= r_pend_h;
                r_act_t <= r_pend_t;
                r_pend  <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st <= IDLE;
        end else begin
            r_st <= w_st_next;
        end
    end

    // FSM next state, frame-start and length-error pulses.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        w_st_next     = r_st;
        w_frame_start = 1'b0;
        w_err_len     = 1'b0;
        unique case (r_st)
            IDLE: begin
                if (w_acc) begin
                    w_frame_start = 1'b1;
                    if (s_last) begin
                        w_err_len = w_len_short;
                    end else if (w_len_overrun) begin
                        w_err_len = 1'b1;
                        w_st_next = DROP;
                    end else begin
                        w_st_next = IN_FRAME;
                    end
                end
            end
            IN_FRAME: begin
                if (w_len_ok) begin
                    w_st_next = IDLE;
                end else if (w_len_short) begin
                    w_err_len = 1'b1;
                    w_st_next = IDLE;
                end else if (w_len_overrun) begin
                    w_err_len = 1'b1;
                    w_st_next = DROP;
                end
            end
            DROP: begin
                if (w_acc && s_last) begin
                    w_st_next = IDLE;
                end
            end
            default: w_st_next = IDLE;
        endcase
    end

endmodule
